// File: rtl/la_readout_sequencer_pkg.sv
// Shared constants and state encoding for the logic-analyzer readout path.
// The analyzer controller imports the same enum to decode sequencer state.
package la_readout_sequencer_pkg;

    localparam int unsigned LA_DEPTH     = 512;
    localparam int unsigned LA_ADDR_W    = 9;
    localparam int unsigned LA_DATA_W    = 12;
    localparam logic [7:0]  LA_SYNC_BYTE = 8'hA5;

    // 3-bit binary encoding, fixed so external decoders stay in step.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SEND_HI = 3'd4,
        ST_SEND_LO = 3'd5,
        ST_DONE    = 3'd6
    } la_state_e;

endpackage

// File: rtl/la_readout_sequencer.sv
// Post-capture readout: walks the capture RAM ring once from the oldest
// sample, emitting a sync byte then each sample as {hi, lo} bytes over a
// valid/ready handshake to the UART transmitter.
module la_readout_sequencer
    import la_readout_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH     = LA_DEPTH,
    parameter int unsigned ADDR_W    = LA_ADDR_W,
    parameter int unsigned DATA_W    = LA_DATA_W,
    parameter logic [7:0]  SYNC_BYTE = LA_SYNC_BYTE
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic              i_abort,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_tx_en,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    la_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [15:0]       sample_ext;

    assign sample_ext = 16'(sample_q);

    // State, ring pointer, sample count and sample holding register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

    // Next-state and Moore outputs; abort overrides any transition, including an accept.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        o_tx_en   = 1'b0;
        o_tx_data = '0;
        o_busy    = 1'b0;
        o_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    ptr_d   = i_start_addr;
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                o_busy    = 1'b1;
                o_tx_en   = 1'b1;
                o_tx_data = SYNC_BYTE;
                if (i_tx_ready) state_d = ST_READ;
            end
            ST_READ: begin
                o_busy    = 1'b1;
                o_rd_en   = 1'b1;
                o_rd_addr = ptr_q;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                o_busy   = 1'b1;
                sample_d = i_rd_data;
                state_d  = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                o_busy    = 1'b1;
                o_tx_en   = 1'b1;
                o_tx_data = sample_ext[15:8];
                if (i_tx_ready) state_d = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                o_busy    = 1'b1;
                o_tx_en   = 1'b1;
                o_tx_data = sample_ext[7:0];
                if (i_tx_ready) begin
                    ptr_d   = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(DEPTH - 1)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && i_abort) state_d = ST_IDLE;
    end

endmodule

// File: tb/tb_la_readout_sequencer.sv
// Directed bench for la_readout_sequencer: a table of whole-frame vectors
// plus hand-written reset, abort and start-while-busy sequences.
module tb_la_readout_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic [8:0]  i_start_addr = '0;
    logic        i_abort = 1'b0;
    logic        o_rd_en;
    logic [8:0]  o_rd_addr;
    logic [11:0] i_rd_data = '0;
    logic        o_tx_en;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;

    la_readout_sequencer dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_start_addr (i_start_addr),
        .i_abort      (i_abort),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_tx_en      (o_tx_en),
        .o_tx_data    (o_tx_data),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Capture RAM model: data = addr*3 truncated to 12 bits, one-cycle latency.
    always @(posedge i_clk) begin
        if (o_rd_en) i_rd_data <= 12'(int'(o_rd_addr) * 3);
    end

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] bytes_q[$];
    logic [8:0] rd_q[$];
    int   start_cyc = -100000;
    int   done_cnt, done_cyc, first_tx, stall_err;
    logic done_busy, busy1;
    logic prev_stall, prev_abort;
    logic [7:0] prev_data;

    // Monitor sampled mid-cycle so it sees the values present at the next rising edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_tx_en && i_tx_ready) bytes_q.push_back(o_tx_data);
            if (o_rd_en) rd_q.push_back(o_rd_addr);
            if (o_done) begin
                done_cnt++;
                done_cyc  = cyc - start_cyc;
                done_busy = o_busy;
            end
            if (cyc - start_cyc == 1) busy1 = o_busy;
            if (first_tx < 0 && o_tx_en) first_tx = cyc - start_cyc;
            if (prev_stall && !prev_abort && (!o_tx_en || o_tx_data != prev_data)) stall_err++;
            prev_stall = o_tx_en && !i_tx_ready;
            prev_data  = o_tx_data;
            prev_abort = i_abort;
        end
    end

    task automatic clear_mon();
        bytes_q.delete();
        rd_q.delete();
        done_cnt   = 0;
        done_cyc   = 0;
        first_tx   = -1;
        stall_err  = 0;
        done_busy  = 1'bx;
        busy1      = 1'bx;
        prev_stall = 1'b0;
        prev_abort = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({o_rd_en, o_rd_addr, o_tx_en, o_tx_data, o_busy, o_done});
    endfunction

    function automatic logic [7:0] byte_at(input int k);
        if (k < bytes_q.size()) return bytes_q[k];
        return 8'hxx;
    endfunction

    // Reference byte k of a frame starting at addr.
    function automatic logic [7:0] exp_byte(input int unsigned addr, input int k);
        int unsigned a;
        logic [11:0] d;
        if (k == 0) return 8'hA5;
        a = (addr + (k - 1) / 2) % 512;
        d = 12'(a * 3);
        if (k % 2 == 1) return {4'h0, d[11:8]};
        return d[7:0];
    endfunction

    function automatic int stream_errs(input int unsigned addr);
        int e = 0;
        for (int k = 0; k < bytes_q.size(); k++) begin
            if (k >= 1025 || bytes_q[k] !== exp_byte(addr, k)) e++;
        end
        return e;
    endfunction

    function automatic int rd_errs(input int unsigned addr);
        int e = 0;
        for (int k = 0; k < rd_q.size(); k++) begin
            if (k >= 512 || rd_q[k] !== 9'((addr + k) % 512)) e++;
        end
        return e;
    endfunction

    task automatic do_frame(input int unsigned addr, input int unsigned pct,
                            input int x1, input int x2, output bit timed_out);
        bit f1 = 1'b0;
        bit f2 = 1'b0;
        int n = 0;
        @(posedge i_clk); #1;
        clear_mon();
        i_start_addr = 9'(addr);
        i_start      = 1'b1;
        start_cyc    = cyc;
        i_tx_ready   = ($urandom_range(0, 99) < pct);
        while (done_cnt == 0 && n < 20000) begin
            @(posedge i_clk); #1;
            i_start    = 1'b0;
            i_tx_ready = ($urandom_range(0, 99) < pct);
            if (x1 >= 0 && !f1 && bytes_q.size() >= x1) begin
                i_start = 1'b1; i_start_addr = 9'd77; f1 = 1'b1;
            end
            if (x2 >= 0 && !f2 && bytes_q.size() >= x2) begin
                i_start = 1'b1; i_start_addr = 9'd77; f2 = 1'b1;
            end
            n++;
        end
        timed_out  = (done_cnt == 0);
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int unsigned addr,
                               input logic [15:0] f16, input logic [15:0] l16,
                               input int exp_done, input bit timed_out);
        check({tag, "_timeout"}, 32'(timed_out), 0);
        check({tag, "_sync_offer_cyc"}, first_tx, 1);
        check({tag, "_busy_cyc1"}, 32'(busy1), 1);
        check({tag, "_byte_count"}, bytes_q.size(), 1025);
        check({tag, "_first_sample"}, {byte_at(1), byte_at(2)}, 32'(f16));
        check({tag, "_last_sample"}, {byte_at(1023), byte_at(1024)}, 32'(l16));
        check({tag, "_stream_errs"}, stream_errs(addr), 0);
        check({tag, "_rd_count"}, rd_q.size(), 512);
        check({tag, "_rd_order_errs"}, rd_errs(addr), 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_in_done"}, 32'(done_busy), 0);
        check({tag, "_stall_errs"}, stall_err, 0);
        if (exp_done != 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
    endtask

    typedef struct {
        string       tag;
        int unsigned addr;
        int unsigned pct;
        logic [15:0] first16;
        logic [15:0] last16;
        int          done_cycle;
    } vec_t;

    vec_t vecs[4];

    initial begin
        bit to;
        bit found;

        vecs[0] = '{"full",   0,   100, 16'h0000, 16'h05FD, 2050};
        vecs[1] = '{"wrap",   510, 100, 16'h05FA, 16'h05F7, 2050};
        vecs[2] = '{"bp30",   0,   30,  16'h0000, 16'h05FD, 0};
        vecs[3] = '{"mid257", 257, 100, 16'h0303, 16'h0300, 2050};

        clear_mon();
        #2 i_rst_n = 1'b0;
        #1 check("reset_outputs", outs(), 0);
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("idle_outputs", outs(), 0);

        foreach (vecs[v]) begin
            do_frame(vecs[v].addr, vecs[v].pct, -1, -1, to);
            check_frame(vecs[v].tag, vecs[v].addr, vecs[v].first16, vecs[v].last16,
                        vecs[v].done_cycle, to);
        end

        // Reset asserted mid-frame clears every output without waiting for a clock edge.
        @(posedge i_clk); #1;
        i_start_addr = 9'd0; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (300) @(posedge i_clk);
        #3;
        check("busy_before_reset", 32'(o_busy), 1);
        i_rst_n = 1'b0;
        #1 check("reset_midframe_outputs", outs(), 0);
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        do_frame(0, 100, -1, -1, to);
        check_frame("after_reset", 0, 16'h0000, 16'h05FD, 2050, to);

        // Abort in SEND_LO of sample 100 with a simultaneous accept.
        @(posedge i_clk); #1;
        clear_mon();
        i_start_addr = 9'd0; i_start = 1'b1; start_cyc = cyc;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            if (bytes_q.size() == 202 && o_tx_en) found = 1'b1;
            else begin
                @(posedge i_clk); #1;
            end
        end
        check("abort_reached_send_lo", 32'(found), 1);
        check("abort_lo_byte", 32'(o_tx_data), 32'h2C);
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        check("abort_idle_outputs", outs(), 0);
        check("abort_byte_delivered", bytes_q.size(), 203);
        do_frame(0, 100, -1, -1, to);
        check_frame("after_abort", 0, 16'h0000, 16'h05FD, 2050, to);

        // Extra start pulses mid-frame must be ignored.
        do_frame(3, 100, 1, 500, to);
        check_frame("start_busy", 3, 16'h0009, 16'h0006, 2050, to);

        // Start and abort together in IDLE stays idle.
        @(posedge i_clk); #1;
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        check("start_abort_idle", outs(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
